// File: rtl/gpio_cfg_serial_xmit_pkg.sv
// ---------------------------------------------------------------------------
// gpio_cfg_serial_xmit_pkg
// Shared definitions for the user-GPIO serial configuration transmitter.
// Holds the pad-count and config-word-width constants that the housekeeping
// block and the pad-frame control chain must agree on. It also holds the
// transmitter state encoding and a small width helper.
// Ports: none (package).
// ---------------------------------------------------------------------------
package gpio_cfg_serial_xmit_pkg;

    // Pad-frame geometry. Five pads are reserved for management functions and
    // six are analog. Neither group sits on the digital configuration chain.
    localparam int MPRJ_IO_PADS       = 38;
    localparam int NUM_RESERVED_PADS  = 5;
    localparam int NUM_ANALOG_PADS    = 6;
    localparam int GPIO_NUM_USER_PADS = MPRJ_IO_PADS - NUM_RESERVED_PADS - NUM_ANALOG_PADS;

    // Width of one pad's configuration word (out/oeb/dm/inp_dis/vtrip/...).
    localparam int GPIO_CFG_BITS      = 13;

    // System clock cycles per serial_clock half-period.
    localparam int GPIO_CFG_CLK_DIV   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LOAD,
        ST_DONE
    } xmit_state_t;

    // Counter width able to hold 0..n-1. The result is never 0 bits, even for n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_cfg_serial_phase.sv
// ---------------------------------------------------------------------------
// gpio_cfg_serial_phase
// Half-period generator for the configuration chain shift clock.
// While run is high, the module counts CLK_DIV system cycles per half-period.
// It toggles the registered serial clock level at the end of each half-period.
// While run is low, the counter is parked and the level is held low. Each bit
// therefore starts with a low half-period.
// Ports:
//   clk         in   system clock
//   rst         in   async active-high reset
//   run         in   enable (high while the transmitter is shifting)
//   phase_tick  out  high in the last cycle of each half-period
//   level       out  registered serial clock level
// ---------------------------------------------------------------------------
module gpio_cfg_serial_phase
    import gpio_cfg_serial_xmit_pkg::*;
#(
    parameter int CLK_DIV = GPIO_CFG_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic phase_tick,
    output logic level
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Half-period counter and clock level.
    // The level flips on the last cycle of every half-period. When run drops,
    // both the counter and the level return to their idle values. The next
    // bit then begins cleanly with serial_clock low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign phase_tick = run && (cnt == CNT_LAST);

endmodule

// File: rtl/gpio_cfg_serial_xmit.sv
// ---------------------------------------------------------------------------
// gpio_cfg_serial_xmit
// Transmitter for the user-GPIO serial configuration chain.
// The transmitter reads one config word per digital user pad, starting with
// the highest pad and working down to pad 0. It shifts each word MSB first
// into the daisy-chained GPIO control blocks, then pulses serial_load so all
// pads latch at once. A separate request pulses serial_resetn low to clear
// the chain.
// Ports:
//   wb_clk_i         in   system clock
//   wb_rst_i         in   async active-high reset
//   xfer_start       in   1-cycle request to (re)load the whole chain
//   chain_clear      in   1-cycle request to pulse serial_resetn low
//   cfg_rd_idx       out  pad index whose config word is being read
//   cfg_rd_data      in   config word for cfg_rd_idx (combinational read)
//   serial_clock     out  chain shift clock (data sampled on rising edge)
//   serial_data_out  out  chain data, MSB first
//   serial_load      out  chain latch strobe
//   serial_resetn    out  chain reset, active low
//   busy             out  transfer in progress
//   done             out  1-cycle pulse at end of transfer
// ---------------------------------------------------------------------------
module gpio_cfg_serial_xmit
    import gpio_cfg_serial_xmit_pkg::*;
#(
    parameter int NUM_PADS = GPIO_NUM_USER_PADS,
    parameter int CFG_BITS = GPIO_CFG_BITS,
    parameter int CLK_DIV  = GPIO_CFG_CLK_DIV
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          xfer_start,
    input  logic                          chain_clear,
    output logic [cnt_width(NUM_PADS)-1:0] cfg_rd_idx,
    input  logic [CFG_BITS-1:0]           cfg_rd_data,
    output logic                          serial_clock,
    output logic                          serial_data_out,
    output logic                          serial_load,
    output logic                          serial_resetn,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = cnt_width(NUM_PADS);
    localparam int BIT_W = cnt_width(CFG_BITS);
    localparam int LD_W  = cnt_width(2 * CLK_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(CFG_BITS - 1);
    localparam logic [LD_W-1:0]  LD_HIGH_END = LD_W'(CLK_DIV - 1);
    localparam logic [LD_W-1:0]  LD_END      = LD_W'(2 * CLK_DIV - 1);

    xmit_state_t          state;
    logic [CFG_BITS-1:0]  shreg;
    logic [CFG_BITS-1:0]  shreg_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [LD_W-1:0]      ld_cnt;
    logic                 clr_hold;
    logic                 phase_tick;
    logic                 sclk_level;
    logic                 bit_end;

    // The shift clock runs only while the FSM is in SHIFT. A bit is finished
    // at the end of its high half-period, which is where serial_clock falls.
    gpio_cfg_serial_phase #(
        .CLK_DIV(CLK_DIV)
    ) u_phase (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .run        (state == ST_SHIFT),
        .phase_tick (phase_tick),
        .level      (sclk_level)
    );

    assign serial_clock = sclk_level;
    assign bit_end      = phase_tick && sclk_level;
    assign shreg_next   = shreg << 1;

    // Main transfer FSM with registered Moore outputs.
    // IDLE waits for a request. FETCH captures the addressed word. SHIFT
    // presents the word MSB first, one bit per serial_clock period. When pad 0
    // has been sent, LOAD drives a high-then-low serial_load window. DONE then
    // signals completion for a single cycle.
    // The chain-clear pulse is stretched to two cycles by clr_hold. Once that
    // pulse ends, or after any reset, serial_resetn returns high on the next
    // clock. An async reset drops serial_resetn immediately. As a result, a
    // partially shifted chain is cleared instead of ever being latched.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state           <= ST_IDLE;
            cfg_rd_idx      <= IDX_LAST;
            shreg           <= '0;
            bit_cnt         <= '0;
            ld_cnt          <= '0;
            clr_hold        <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
            serial_resetn   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;

            if (clr_hold) begin
                clr_hold      <= 1'b0;
                serial_resetn <= 1'b0;
            end else begin
                serial_resetn <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (xfer_start) begin
                        state      <= ST_FETCH;
                        busy       <= 1'b1;
                        cfg_rd_idx <= IDX_LAST;
                    end else if (chain_clear) begin
                        serial_resetn <= 1'b0;
                        clr_hold      <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    shreg           <= cfg_rd_data;
                    serial_data_out <= cfg_rd_data[CFG_BITS-1];
                    bit_cnt         <= BIT_LAST;
                    state           <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (bit_end) begin
                        if (bit_cnt != '0) begin
                            bit_cnt         <= bit_cnt - 1'b1;
                            shreg           <= shreg_next;
                            serial_data_out <= shreg_next[CFG_BITS-1];
                        end else begin
                            serial_data_out <= 1'b0;
                            if (cfg_rd_idx == '0) begin
                                state       <= ST_LOAD;
                                serial_load <= 1'b1;
                                ld_cnt      <= '0;
                            end else begin
                                cfg_rd_idx  <= cfg_rd_idx - 1'b1;
                                state       <= ST_FETCH;
                            end
                        end
                    end
                end

                ST_LOAD: begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_cnt == LD_HIGH_END) begin
                        serial_load <= 1'b0;
                    end
                    if (ld_cnt == LD_END) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    cfg_rd_idx <= IDX_LAST;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_cfg_serial_xmit.sv
// ---------------------------------------------------------------------------
// tb_gpio_cfg_serial_xmit
// Bench for the GPIO configuration chain transmitter. Two instances are used:
// instance A has the default parameters (27 pads, 13 bits, CLK_DIV 2) and
// instance B has 2 pads with CLK_DIV 1. Each instance feeds a behavioural
// model of the pad chain, built from shift registers and load latches. The
// config word is presented only in the expected FETCH cycle; every other
// cycle carries random garbage.
// ---------------------------------------------------------------------------
module tb_gpio_cfg_serial_xmit;

    localparam int NA = 27;
    localparam int NB = 2;
    localparam int CB = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, start_a, clr_a;
    logic [4:0]    idx_a;
    logic [CB-1:0] data_a;
    logic          sclk_a, sdo_a, sload_a, srstn_a, busy_a, done_a;

    logic          rst_b, start_b, clr_b;
    logic [0:0]    idx_b;
    logic [CB-1:0] data_b;
    logic          sclk_b, sdo_b, sload_b, srstn_b, busy_b, done_b;

    int pc = 0;
    int errors = 0;
    int checks = 0;
    int mode_a = 0;
    int t_a = -1000;
    int t_b = -1000;
    logic [CB-1:0] garb_a = '0;
    logic [CB-1:0] garb_b = '0;

    logic [NA*CB-1:0] chain_a = '0, latch_a = '0;
    logic [NB*CB-1:0] chain_b = '0, latch_b = '0;
    bit sclk_pa = 0, sload_pa = 0, sclk_pb = 0, sload_pb = 0;
    int rise_a = 0, rise_b = 0;
    int load_cnt_a = 0, load_cnt_b = 0;
    int load_first_a = 0, load_first_b = 0;
    int rn_busy_a = 0;

    logic [CB-1:0] wordq_a[$];
    logic [CB-1:0] wordq_b[$];
    bit            bitq_a[$];

    function automatic logic [CB-1:0] word_a(input int m, input int k);
        if (m == 0) return 13'h1000 | 13'(k);
        return (k == 26) ? 13'h1FFF : 13'h0000;
    endfunction

    function automatic logic [CB-1:0] word_b(input int k);
        return (k == 0) ? 13'h0B6D : 13'h1492;
    endfunction

    // The register file responds correctly only in the FETCH cycle the timing implies.
    assign data_a = (((pc - t_a - 1) % 53) == 0) ? word_a(mode_a, int'(idx_a)) : garb_a;
    assign data_b = (((pc - t_b - 1) % 27) == 0) ? word_b(int'(idx_b)) : garb_b;

    gpio_cfg_serial_xmit dut_a (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst_a),
        .xfer_start      (start_a),
        .chain_clear     (clr_a),
        .cfg_rd_idx      (idx_a),
        .cfg_rd_data     (data_a),
        .serial_clock    (sclk_a),
        .serial_data_out (sdo_a),
        .serial_load     (sload_a),
        .serial_resetn   (srstn_a),
        .busy            (busy_a),
        .done            (done_a)
    );

    gpio_cfg_serial_xmit #(
        .NUM_PADS (NB),
        .CFG_BITS (CB),
        .CLK_DIV  (1)
    ) dut_b (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst_b),
        .xfer_start      (start_b),
        .chain_clear     (clr_b),
        .cfg_rd_idx      (idx_b),
        .cfg_rd_data     (data_b),
        .serial_clock    (sclk_b),
        .serial_data_out (sdo_b),
        .serial_load     (sload_b),
        .serial_resetn   (srstn_b),
        .busy            (busy_b),
        .done            (done_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the request for one cycle and returns at the next negedge.
    task automatic applyStimulus(input int dut, input bit start, input bit clr);
        if (dut == 0) begin
            if (start && !busy_a) t_a = pc;
            start_a = start;
            clr_a   = clr;
        end else begin
            if (start && !busy_b) t_b = pc;
            start_b = start;
            clr_b   = clr;
        end
        @(negedge clk);
        start_a = 1'b0; clr_a = 1'b0;
        start_b = 1'b0; clr_b = 1'b0;
    endtask

    task automatic waitDone(input int dut);
        int n = 0;
        while (((dut == 0) ? done_a : done_b) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput((dut == 0) ? "done_seen_a" : "done_seen_b",
                    (dut == 0) ? done_a : done_b, 1);
    endtask

    always @(posedge clk) pc <= pc + 1;

    // Chain models are sampled mid-cycle, away from the DUT's clock edge.
    always @(negedge clk) begin
        garb_a = 13'($urandom);
        garb_b = 13'($urandom);

        if (srstn_a !== 1'b1) chain_a = '0;
        else if (sclk_a && !sclk_pa) begin
            rise_a++;
            chain_a = {chain_a[NA*CB-2:0], sdo_a};
            if (bitq_a.size() > 0) checkOutput("bit_a", sdo_a, bitq_a.pop_front());
        end
        if (sload_a && !sload_pa) latch_a = chain_a;
        if (sload_a) begin
            if (load_cnt_a == 0) load_first_a = pc;
            load_cnt_a++;
        end
        if (busy_a && srstn_a !== 1'b1) rn_busy_a++;
        sclk_pa  = sclk_a;
        sload_pa = sload_a;

        if (srstn_b !== 1'b1) chain_b = '0;
        else if (sclk_b && !sclk_pb) begin
            rise_b++;
            chain_b = {chain_b[NB*CB-2:0], sdo_b};
        end
        if (sload_b && !sload_pb) latch_b = chain_b;
        if (sload_b) begin
            if (load_cnt_b == 0) load_first_b = pc;
            load_cnt_b++;
        end
        sclk_pb  = sclk_b;
        sload_pb = sload_b;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b1; start_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; clr_b = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        checkOutput("rst_sclk_a",  sclk_a,  0);
        checkOutput("rst_sdo_a",   sdo_a,   0);
        checkOutput("rst_sload_a", sload_a, 0);
        checkOutput("rst_srstn_a", srstn_a, 0);
        checkOutput("rst_busy_a",  busy_a,  0);
        checkOutput("rst_done_a",  done_a,  0);
        checkOutput("rst_idx_a",   idx_a,   26);
        checkOutput("rst_idx_b",   idx_b,   1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        checkOutput("rstn_release_a", srstn_a, 1);
        checkOutput("rstn_release_b", srstn_b, 1);

        // chain_clear alone in IDLE: exactly two low cycles
        applyStimulus(0, 0, 1);
        checkOutput("clr_low1", srstn_a, 0);
        @(negedge clk);
        checkOutput("clr_low2", srstn_a, 0);
        @(negedge clk);
        checkOutput("clr_high", srstn_a, 1);
        checkOutput("clr_busy", busy_a, 0);

        // Single-bit pattern, start together with chain_clear, late requests ignored
        mode_a = 1;
        rise_a = 0; rn_busy_a = 0; load_cnt_a = 0;
        for (int k = 0; k < NA; k++) wordq_a.push_back(word_a(1, k));
        for (int i = 0; i < NA*CB; i++) bitq_a.push_back(i < CB);
        applyStimulus(0, 1, 1);
        checkOutput("both_busy", busy_a, 1);
        checkOutput("both_srstn", srstn_a, 1);
        while (pc < t_a + 500) @(negedge clk);
        applyStimulus(0, 1, 0);
        while (pc < t_a + 600) @(negedge clk);
        applyStimulus(0, 0, 1);
        waitDone(0);
        checkOutput("sb_latency", pc - t_a, 1436);
        checkOutput("sb_rises", rise_a, 351);
        checkOutput("sb_bits_left", bitq_a.size(), 0);
        checkOutput("sb_rstn_busy", rn_busy_a, 0);
        checkOutput("sb_load_first", load_first_a - t_a, 1432);
        checkOutput("sb_load_cnt", load_cnt_a, 2);
        for (int k = 0; k < NA; k++)
            checkOutput($sformatf("sb_pad%0d", k), latch_a[k*CB +: CB], wordq_a.pop_front());
        @(negedge clk);
        checkOutput("idle_busy", busy_a, 0);
        checkOutput("idle_idx", idx_a, 26);

        // Reset in the middle of a transfer
        mode_a = 0;
        load_cnt_a = 0;
        applyStimulus(0, 1, 0);
        while (pc < t_a + 700) @(negedge clk);
        rst_a = 1'b1;
        #1;
        checkOutput("abort_srstn", srstn_a, 0);
        checkOutput("abort_busy",  busy_a,  0);
        checkOutput("abort_idx",   idx_a,   26);
        checkOutput("abort_sload", sload_a, 0);
        checkOutput("abort_sdo",   sdo_a,   0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_no_load", load_cnt_a, 0);
        checkOutput("abort_idle", busy_a, 0);

        // Full transfer, words 0x1000|k
        load_cnt_a = 0;
        for (int k = 0; k < NA; k++) wordq_a.push_back(word_a(0, k));
        applyStimulus(0, 1, 0);
        waitDone(0);
        checkOutput("full_latency", pc - t_a, 1436);
        checkOutput("full_load_first", load_first_a - t_a, 1432);
        checkOutput("full_load_cnt", load_cnt_a, 2);
        for (int k = 0; k < NA; k++)
            checkOutput($sformatf("full_pad%0d", k), latch_a[k*CB +: CB], wordq_a.pop_front());

        // Small chain, CLK_DIV 1
        rise_b = 0; load_cnt_b = 0;
        for (int k = 0; k < NB; k++) wordq_b.push_back(word_b(k));
        applyStimulus(1, 1, 0);
        waitDone(1);
        checkOutput("b_latency", pc - t_b, 57);
        checkOutput("b_load_first", load_first_b - t_b, 55);
        checkOutput("b_load_cnt", load_cnt_b, 1);
        checkOutput("b_rises", rise_b, 26);
        for (int k = 0; k < NB; k++)
            checkOutput($sformatf("b_pad%0d", k), latch_b[k*CB +: CB], wordq_b.pop_front());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
